// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared definitions for the multi-cycle datapath: opcode and
//                funct encodings, FSM state enum, ALU operation encoding,
//                instruction classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef enum logic [2:0] {
        K_RTYPE   = 3'd0,
        K_ADDI    = 3'd1,
        K_LW      = 3'd2,
        K_SW      = 3'd3,
        K_ILLEGAL = 3'd4
    } instr_kind_t;

    // Maps a legal R-type funct to its ALU operation; unknown functs fall
    // back to ADD (they are rejected by classify before reaching the ALU).
    function automatic alu_op_t funct_to_alu_op(input logic [5:0] funct);
        alu_op_t op;
        op = ALU_ADD;
        case (funct)
            c_FN_SUB: op = ALU_SUB;
            c_FN_AND: op = ALU_AND;
            c_FN_OR:  op = ALU_OR;
            c_FN_SLT: op = ALU_SLT;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic instr_kind_t classify(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        instr_kind_t k;
        k = K_ILLEGAL;
        case (opcode)
            c_OP_RTYPE: begin
                case (funct)
                    c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: k = K_RTYPE;
                    default: k = K_ILLEGAL;
                endcase
            end
            c_OP_ADDI: k = K_ADDI;
            c_OP_LW:   k = K_LW;
            c_OP_SW:   k = K_SW;
            default:   k = K_ILLEGAL;
        endcase
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_multiciclo_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_multiciclo_if
//  Description : Instruction handshake, retire status and debug read port of
//                the multi-cycle datapath.
//                master: instruction source / observer
//                slave : datapath
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_multiciclo_if #(
    parameter int WIDTH = 32
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instruccion;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] resultado;
    logic             zf;
    logic [4:0]       dbg_sel;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output instr_valid, instruccion, dbg_sel,
        input  instr_ready, done, error, resultado, zf, dbg_data
    );

    modport slave (
        input  instr_valid, instruccion, dbg_sel,
        output instr_ready, done, error, resultado, zf, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/datapath_multiciclo_alu_n.sv
`default_nettype none
// ============================================================================
//  Module      : alu_n
//  Description : Combinational WIDTH-bit ALU (add, sub, and, or, signed slt).
//                Ports: i_a, i_b operands; i_alu_op operation;
//                       o_res result; o_zf result-is-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
import datapath_pkg::*;

module alu_n #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_alu_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zf
);
    always_comb begin
        o_res = '0;
        case (i_alu_op)
            ALU_ADD: o_res = i_a + i_b;
            ALU_SUB: o_res = i_a - i_b;
            ALU_AND: o_res = i_a & i_b;
            ALU_OR:  o_res = i_a | i_b;
            ALU_SLT: o_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_res = '0;
        endcase
    end

    assign o_zf = (o_res == '0);
endmodule
`default_nettype wire

// File: rtl/datapath_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_multiciclo
//  Description : Multi-cycle MIPS-style datapath (R-type, addi, lw, sw) with
//                one shared ALU, inline register file and data memory.
//                Ports: clk, rst_n (async, active low);
//                       bus (slave): instr_valid/instr_ready/instruccion,
//                       done/error/resultado/zf, dbg_sel/dbg_data.
//  Revision    : 1.0 - initial release
// ============================================================================
import datapath_pkg::*;

module datapath_multiciclo #(
    parameter int WIDTH     = 32,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    datapath_multiciclo_if.slave  bus
);
    localparam int c_RW = $clog2(NREG);
    localparam int c_AW = $clog2(MEM_DEPTH);

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_mem  [MEM_DEPTH];

    state_t           r_state, w_state_next;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_a, r_b, r_alu_out, r_mdr;
    instr_kind_t      r_kind, w_kind;
    alu_op_t          r_op, w_op;
    logic             r_zf;

    logic             w_ready, w_done, w_error;
    logic [WIDTH-1:0] w_imm_sext, w_alu_b, w_alu_res, w_result;
    logic             w_alu_zf;
    logic [c_RW-1:0]  w_rs, w_rt, w_rd, w_dest;
    logic [c_AW-1:0]  w_addr;
    logic             w_unused;

    assign w_rs       = r_ir[21 +: c_RW];
    assign w_rt       = r_ir[16 +: c_RW];
    assign w_rd       = r_ir[11 +: c_RW];
    assign w_kind     = classify(r_ir[31:26], r_ir[5:0]);
    assign w_op       = (w_kind == K_RTYPE) ? funct_to_alu_op(r_ir[5:0]) : ALU_ADD;
    assign w_imm_sext = WIDTH'($signed(r_ir[15:0]));
    // addi/lw/sw all use the ALU as an adder against the immediate
    assign w_alu_b    = (r_kind == K_RTYPE) ? r_b : w_imm_sext;
    assign w_addr     = r_alu_out[c_AW-1:0];
    assign w_dest     = (r_kind == K_RTYPE) ? w_rd : w_rt;
    assign w_result   = (r_state == ST_WB && r_kind == K_LW) ? r_mdr : r_alu_out;

    alu_n #(.WIDTH(WIDTH)) u_alu (
        .i_a      (r_a),
        .i_b      (w_alu_b),
        .i_alu_op (r_op),
        .o_res    (w_alu_res),
        .o_zf     (w_alu_zf)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) w_state_next = ST_DECODE;
            end
            ST_DECODE: w_state_next = (w_kind == K_ILLEGAL) ? ST_WB : ST_EXEC;
            ST_EXEC:   w_state_next = (r_kind == K_LW || r_kind == K_SW) ? ST_MEM : ST_WB;
            ST_MEM: begin
                // sw retires here; lw still has to write back the loaded word
                if (r_kind == K_SW) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_WB: begin
                w_done       = 1'b1;
                w_error      = (r_kind == K_ILLEGAL);
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
            r_kind    <= K_RTYPE;
            r_op      <= ALU_ADD;
            r_zf      <= 1'b0;
            for (int i = 0; i < NREG; i++)      r_regs[i] <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i]  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.instr_valid) r_ir <= bus.instruccion;
                ST_DECODE: begin
                    r_a    <= r_regs[w_rs];
                    r_b    <= r_regs[w_rt];
                    r_kind <= w_kind;
                    r_op   <= w_op;
                end
                ST_EXEC: r_alu_out <= w_alu_res;
                ST_MEM: begin
                    if (r_kind == K_SW) r_mem[w_addr] <= r_b;
                    else                r_mdr         <= r_mem[w_addr];
                end
                ST_WB: begin
                    // register 0 is never written so it keeps reading zero
                    if (r_kind != K_ILLEGAL && w_dest != '0)
                        r_regs[w_dest] <= w_result;
                end
                default: ;
            endcase
            if (w_done && !w_error) r_zf <= (w_result == '0);
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.done        = w_done;
    assign bus.error       = w_error;
    assign bus.resultado   = w_result;
    // Live flag during the retire cycle, held value otherwise
    assign bus.zf          = (w_done && !w_error) ? (w_result == '0) : r_zf;
    assign bus.dbg_data    = r_regs[bus.dbg_sel[c_RW-1:0]];

    assign w_unused = &{1'b0, r_ir, bus.dbg_sel, r_alu_out, w_alu_zf};

endmodule
`default_nettype wire

// File: tb/tb_datapath_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_multiciclo
//  Description : Self-checking bench for datapath_multiciclo: directed
//                program plus randomized instructions checked every cycle
//                against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_multiciclo;
    localparam int WIDTH     = 32;
    localparam int NREG      = 32;
    localparam int MEM_DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    datapath_multiciclo_if #(.WIDTH(WIDTH)) bus ();

    datapath_multiciclo #(
        .WIDTH(WIDTH), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // instruction-level model
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [MEM_DEPTH];
    logic        m_zf;

    // expectation of the instruction in flight
    bit          in_flight = 1'b0;
    int          cyc, accepts = 0;
    int          e_lat, e_dest, e_addr;
    bit          e_err, e_wr_reg, e_mem_wr;
    logic [31:0] e_res, e_mem_data;
    // actuals captured at the last retire
    int          last_lat;
    logic [31:0] last_res;
    logic        last_zf, last_err;
    bit          was_busy;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // What the instruction must do, from the ISA rules
    task automatic predict(input logic [31:0] ins);
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        logic [31:0] a, b, sx, sum;
        op = ins[31:26]; fn = ins[5:0];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        a = m_regs[rs]; b = m_regs[rt];
        sx  = {{16{ins[15]}}, ins[15:0]};
        sum = a + sx;
        e_err = 0; e_wr_reg = 0; e_mem_wr = 0; e_dest = 0; e_res = 0;
        e_addr = 0; e_mem_data = 0; e_lat = 2;
        case (op)
            6'h00: begin
                e_lat = 3; e_wr_reg = 1; e_dest = rd;
                case (fn)
                    6'h20: e_res = a + b;
                    6'h22: e_res = a - b;
                    6'h24: e_res = a & b;
                    6'h25: e_res = a | b;
                    6'h2A: e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin e_err = 1; e_lat = 2; e_wr_reg = 0; end
                endcase
            end
            6'h08: begin e_lat = 3; e_wr_reg = 1; e_dest = rt; e_res = sum; end
            6'h23: begin
                e_lat = 4; e_wr_reg = 1; e_dest = rt;
                e_addr = int'(sum % 32'(MEM_DEPTH));
                e_res = m_mem[e_addr];
            end
            6'h2B: begin
                e_lat = 3; e_mem_wr = 1; e_res = sum;
                e_addr = int'(sum % 32'(MEM_DEPTH));
                e_mem_data = b;
            end
            default: begin e_err = 1; e_lat = 2; end
        endcase
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)        m_regs[i] = '0;
            for (int i = 0; i < MEM_DEPTH; i++) m_mem[i]  = '0;
            m_zf = 1'b0;
            in_flight = 1'b0;
            cyc = 0;
        end else begin
            was_busy = in_flight;
            chk("instr_ready", 32'(bus.instr_ready), 32'(!was_busy));
            chk("dbg_data", bus.dbg_data, m_regs[bus.dbg_sel]);
            if (was_busy) begin
                cyc++;
                if (bus.done) begin
                    chk("latency", cyc, e_lat);
                    chk("error", 32'(bus.error), 32'(e_err));
                    if (!e_err) chk("resultado", bus.resultado, e_res);
                    chk("zf_retire", 32'(bus.zf), e_err ? 32'(m_zf) : 32'(e_res == 0));
                    last_lat = cyc; last_res = bus.resultado;
                    last_zf = bus.zf; last_err = bus.error;
                    if (e_wr_reg && e_dest != 0) m_regs[e_dest] = e_res;
                    if (e_mem_wr) m_mem[e_addr] = e_mem_data;
                    if (!e_err) m_zf = (e_res == 0);
                    in_flight = 1'b0;
                end else begin
                    chk("zf_hold_busy", 32'(bus.zf), 32'(m_zf));
                    if (cyc >= 8) begin
                        n_checks++; n_err++;
                        $display("FAIL done_timeout: got no done after %0d cycles, required %0d", cyc, e_lat);
                        in_flight = 1'b0;
                    end
                end
            end else begin
                chk("done_idle", 32'(bus.done), 32'd0);
                chk("error_idle", 32'(bus.error), 32'd0);
                chk("zf_hold_idle", 32'(bus.zf), 32'(m_zf));
            end
            if (bus.instr_valid && bus.instr_ready) begin
                predict(bus.instruccion);
                in_flight = 1'b1;
                cyc = 0;
                accepts++;
            end
        end
    end

    task automatic issue(input logic [31:0] ins);
        int b;
        @(posedge clk); #1;
        b = 0;
        while (!bus.instr_ready && b < 20) begin @(posedge clk); #1; b++; end
        chk("ready_before_issue", 32'(bus.instr_ready), 32'd1);
        bus.instruccion = ins;
        bus.instr_valid = 1'b1;
        bus.dbg_sel     = 5'($urandom);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instruccion = $urandom;
        b = 0;
        while (in_flight && b < 20) begin
            bus.dbg_sel = 5'($urandom);
            @(posedge clk); #1;
            b++;
        end
    endtask

    task automatic peek(input string nm, input int idx, input logic [31:0] exp);
        bus.dbg_sel = 5'(idx);
        #1;
        chk(nm, bus.dbg_data, exp);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: fn = 6'($urandom);
        endcase
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'($urandom), fn};
            4, 5:       return {6'h08, rs, rt, 16'($urandom)};
            6:          return {6'h23, rs, rt, 16'($urandom_range(0, 80) - 40)};
            7:          return {6'h2B, rs, rt, 16'($urandom_range(0, 80) - 40)};
            8:          return {6'($urandom), 26'($urandom)};
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, b;
        bus.instr_valid = 1'b0;
        bus.instruccion = '0;
        bus.dbg_sel     = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_ready", 32'(bus.instr_ready), 32'd1);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_error", 32'(bus.error), 32'd0);
        chk("reset_resultado", bus.resultado, 32'd0);
        chk("reset_zf", 32'(bus.zf), 32'd0);
        for (int i = 0; i < 32; i++) peek("reset_reg", i, 32'd0);

        issue(enc_i(6'h08, 1, 0, 16'd5));
        chk("addi_r1_lat", last_lat, 3); chk("addi_r1_zf", 32'(last_zf), 32'd0);
        issue(enc_i(6'h08, 2, 0, 16'hFFFD));
        chk("addi_r2_res", last_res, 32'hFFFF_FFFD);
        issue(enc_r(6'h20, 3, 1, 2));
        chk("add_r3_res", last_res, 32'd2); chk("add_r3_lat", last_lat, 3);
        issue(enc_r(6'h22, 4, 1, 1));
        chk("sub_r4_zf", 32'(last_zf), 32'd1);
        issue(enc_r(6'h2A, 5, 2, 1));
        chk("slt_r5_res", last_res, 32'd1);
        issue(enc_r(6'h25, 6, 1, 2));
        issue(enc_i(6'h2B, 1, 0, 16'd4));
        chk("sw_lat", last_lat, 3);
        issue(enc_i(6'h23, 7, 0, 16'd4));
        chk("lw_lat", last_lat, 4); chk("lw_res", last_res, 32'd5);
        issue(enc_i(6'h2B, 2, 0, 16'(MEM_DEPTH + 4)));
        issue(enc_i(6'h23, 8, 0, 16'd4));
        chk("lw_wrap_res", last_res, 32'hFFFF_FFFD);
        issue({6'b111111, 26'h3FF_FFFF});
        chk("illegal_lat", last_lat, 2); chk("illegal_err", 32'(last_err), 32'd1);
        issue(enc_i(6'h08, 0, 0, 16'd7));
        chk("addi_r0_res", last_res, 32'd7);
        @(posedge clk); #1;
        peek("r0", 0, 32'd0);
        peek("r1", 1, 32'd5);
        peek("r2", 2, 32'hFFFF_FFFD);
        peek("r3", 3, 32'd2);
        peek("r4", 4, 32'd0);
        peek("r5", 5, 32'd1);
        peek("r6", 6, 32'hFFFF_FFFD);
        peek("r7", 7, 32'd5);
        peek("r8", 8, 32'hFFFF_FFFD);

        // instr_valid held high through a whole instruction
        @(posedge clk); #1;
        acc0 = accepts;
        bus.instruccion = enc_i(6'h08, 10, 10, 16'd1);
        bus.instr_valid = 1'b1;
        b = 0;
        while (!in_flight && b < 10) begin @(posedge clk); #1; b++; end
        b = 0;
        while (in_flight && b < 20) begin @(posedge clk); #1; b++; end
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_accepts", accepts - acc0, 1);
        peek("hold_r10", 10, 32'd1);

        for (int n = 0; n < 250; n++) issue(rand_instr());

        // reset during EXEC of addi r9,r0,1
        @(posedge clk); #1;
        bus.instruccion = enc_i(6'h08, 9, 0, 16'd1);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        peek("abort_r9", 9, 32'd0);
        repeat (4) @(posedge clk);

        for (int n = 0; n < 60; n++) issue(rand_instr());
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/datapath_multiciclo.md
# datapath_multiciclo

Multi-cycle, parametrised successor to the single-cycle R-type datapath. It accepts one 32-bit MIPS-style instruction per valid/ready handshake. The instruction then runs through DECODE/EXEC/MEM/WB states, sharing one ALU and one data memory. It supports R-type ALU ops, addi, lw and sw, flags illegal encodings, and exposes a debug register-read port for verification.

## Interface
- WIDTH, 32, datapath and register width (≥8)
- NREG, 32, register count, power of two ≤32; register index = low clog2(NREG) bits of field
- MEM_DEPTH, 32, data memory words, power of two
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruccion is valid
- instr_ready  out  1  block idle, can accept
- instruccion  in  32  rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0] opcode[31:26]
- done  out  1  one-cycle pulse, instruction retired
- error  out  1  with done: illegal encoding, nothing written
- resultado  out  WIDTH  ALU result (addr for lw/sw, loaded data for lw); valid with done
- zf  out  1  resultado==0 for last retired non-illegal instruction; holds otherwise
- dbg_sel  in  5  debug register index
- dbg_data  out  WIDTH  combinational read of register dbg_sel

## Operation
- Opcodes: 000000 R-type, 001000 addi, 100011 lw, 101011 sw; anything else is illegal
- Funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1); anything else is illegal
- Address: (rs + sext(imm)) mod MEM_DEPTH, word-indexed; imm is sign-extended to WIDTH
- Writes: R-type → rd; addi/lw → rt. Register 0 always reads zero; writes to it are dropped, but resultado still reports the value
- Arithmetic wraps modulo 2^WIDTH; no overflow trap
- FSM states:
  - IDLE: instr_ready=1; on handshake, latch IR, go to DECODE
  - DECODE: read rs, rt into A, B; classify; illegal → WB with error
  - EXEC: ALU computes into ALUOut; R/addi → WB, lw/sw → MEM
  - MEM: sw writes mem[addr]=B, then done, then IDLE; lw latches MDR, then WB
  - WB: commit the write (skipped if error); done=1; back to IDLE
- instr_valid outside IDLE is ignored; no queueing

## Timing
- Handshake edge = cycle 0. done is high in cycle:
  - 3 for R-type and addi
  - 3 for sw
  - 4 for lw
  - 2 for illegal
- Next handshake can occur in the cycle after done (IDLE)
- Register and memory writes are visible on dbg_data/next instruction from the edge ending the done cycle
- Reset values:
  - state IDLE, instr_ready=1, done=0, error=0, resultado=0, zf=0
  - all registers 0, all memory words 0
- Reset mid-instruction aborts: no register or memory write from the aborted instruction, no done

## Structure
- Package datapath_pkg holds:
  - opcode and funct constants
  - FSM state enum (IDLE, DECODE, EXEC, MEM, WB)
  - alu_op encoding
- Sub-module alu_n: parametrised combinational ALU (WIDTH, alu_op) returning res and zf
- Register file and memory stay inline

## Test plan
- Reset: release rst_n → instr_ready=1, done=0; dbg_data=0 for indices 0..31
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2:
  - r1=5, r2=0xFFFFFFFD, r3=2
  - each done at cycle 3, zf=0
- sub r4,r1,r1 → r4=0, zf=1; slt r5,r2,r1 → r5=1; or r6,r1,r2 → 0xFFFFFFFD
- sw r1,4(r0) done at cycle 3; lw r7,4(r0) done at cycle 4 with r7=5, resultado=5
- sw r2,(MEM_DEPTH+4)(r0); lw r8,4(r0) → r8=0xFFFFFFFD (address wrap)
- Illegal and reset cases:
  - Opcode 111111 → done+error at cycle 2, no state change
  - addi r0,r0,7 → r0 stays 0, resultado=7
  - instr_valid held high while busy → exactly one accept per instruction
  - rst_n pulsed low during EXEC of addi r9,r0,1 → r9=0, no done, instr_ready=1
